// File: rtl/regfile_wb_sched_pkg.sv
// Shared types for the register-file write-back scheduler: architectural
// register addresses, data words and the queued write-back entry.
package regfile_wb_sched_pkg;

  localparam int NUM_CREGS = 32;
  localparam int CREG_AW   = 5;
  localparam int WORD_W    = 32;

  typedef logic [WORD_W-1:0]  word_t;
  typedef logic [CREG_AW-1:0] creg_addr_t;

  typedef struct packed {
    creg_addr_t wa;
    word_t      wd;
  } wb_entry_t;

  // One-hot register mask, all-zero when not enabled.
  function automatic logic [NUM_CREGS-1:0] creg_onehot(input creg_addr_t a, input logic en);
    logic [NUM_CREGS-1:0] v;
    v    = '0;
    v[a] = en;
    return v;
  endfunction

endpackage

// File: rtl/regfile_wb_sched_fifo.sv
// Synchronous FIFO of write-back entries with registered full/empty and an
// associative lookup telling whether any queued entry targets a register.
module wb_fifo
  import regfile_wb_sched_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  wb_entry_t  push_data,
  input  logic       pop,
  output wb_entry_t  head,
  output logic       full,
  output logic       empty,
  input  creg_addr_t query_wa,
  output logic       query_hit
);

  localparam int PTR_W = $clog2(DEPTH);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic [PTR_W:0]   used;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign used    = wr_ptr - rd_ptr;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[PTR_W-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is not reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    logic [PTR_W-1:0] offset;
    query_hit = 1'b0;
    offset    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset = PTR_W'(i) - rd_ptr[PTR_W-1:0];
      if (((PTR_W+1)'(offset) < used) && (mem[i].wa == query_wa)) query_hit = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler: shares the register-file write port between the WB
// stage and a long-latency unit, and stalls decode on pending destinations.
module regfile_wb_sched
  import regfile_wb_sched_pkg::*;
#(
  parameter int MAX_PENDING = 4,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_wa,
  input  logic [31:0] pipe_wd,
  input  logic [4:0]  id_ra1,
  input  logic [4:0]  id_ra2,
  input  logic        id_we,
  input  logic [4:0]  id_wa,
  output logic        id_stall,
  input  logic        lu_req_valid,
  input  logic [4:0]  lu_req_wa,
  output logic        lu_req_ready,
  input  logic        lu_resp_valid,
  input  logic [4:0]  lu_resp_wa,
  input  logic [31:0] lu_resp_wd,
  output logic        lu_resp_ready,
  output logic        rf_we,
  output logic [4:0]  rf_wa,
  output logic [31:0] rf_wd,
  output logic [31:0] pending,
  output logic        err
);

  localparam int CNT_W = $clog2(MAX_PENDING + 1);

  logic [CNT_W-1:0]     count_q, count_d;
  logic [NUM_CREGS-1:0] pending_q, pending_d;
  logic                 err_q, err_d;

  wb_entry_t resp_entry;
  wb_entry_t fifo_head;
  logic      fifo_full;
  logic      fifo_empty;
  logic      fifo_hit;
  logic      fifo_pop;
  logic      pipe_busy;
  logic      issue_fire;
  logic      resp_fire;

  assign resp_entry = '{wa: lu_resp_wa, wd: lu_resp_wd};

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (resp_fire),
    .push_data (resp_entry),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .query_wa  (lu_resp_wa),
    .query_hit (fifo_hit)
  );

  // A WB write to r0 is architecturally a no-op, so it leaves the port free.
  assign pipe_busy     = pipe_we && (pipe_wa != '0);
  assign fifo_pop      = !pipe_busy && !fifo_empty;

  assign lu_resp_ready = !fifo_full;
  assign resp_fire     = lu_resp_valid && lu_resp_ready;

  // Refusing a second issue to a pending register rules out same-cycle set and clear.
  assign lu_req_ready  = (count_q < CNT_W'(MAX_PENDING)) &&
                         !((lu_req_wa != '0) && pending_q[lu_req_wa]);
  assign issue_fire    = lu_req_valid && lu_req_ready;

  always_comb begin
    rf_we = 1'b0;
    rf_wa = '0;
    rf_wd = '0;
    if (pipe_busy) begin
      rf_we = 1'b1;
      rf_wa = pipe_wa;
      rf_wd = pipe_wd;
    end else if (!fifo_empty) begin
      rf_we = (fifo_head.wa != '0);
      rf_wa = fifo_head.wa;
      rf_wd = fifo_head.wd;
    end
  end

  always_comb begin
    count_d = count_q;
    err_d   = err_q;

    unique case ({issue_fire, fifo_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01: begin
        if (count_q == '0) err_d = 1'b1;
        else               count_d = count_q - 1'b1;
      end
      default: count_d = count_q;
    endcase

    // A result nobody is waiting for: not pending and not already queued.
    if (resp_fire && (lu_resp_wa != '0) && !pending_q[lu_resp_wa] && !fifo_hit)
      err_d = 1'b1;

    // The clear lands the cycle after the register file write, so the stall
    // drops exactly when readers can see the new value.
    pending_d    = (pending_q & ~creg_onehot(fifo_head.wa, fifo_pop)) |
                   creg_onehot(lu_req_wa, issue_fire);
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q   <= '0;
      pending_q <= '0;
      err_q     <= 1'b0;
    end else begin
      count_q   <= count_d;
      pending_q <= pending_d;
      err_q     <= err_d;
    end
  end

  assign id_stall = pending_q[id_ra1] | pending_q[id_ra2] | (id_we & pending_q[id_wa]);
  assign pending  = pending_q;
  assign err      = err_q;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Self-checking bench for regfile_wb_sched: hazard vector table, scoreboard of
// long-latency write-backs, and directed sequences for the multi-cycle cases.
module tb_regfile_wb_sched;

  logic        clk;
  logic        reset;
  logic        pipe_we;
  logic [4:0]  pipe_wa;
  logic [31:0] pipe_wd;
  logic [4:0]  id_ra1, id_ra2, id_wa;
  logic        id_we;
  logic        id_stall;
  logic        lu_req_valid;
  logic [4:0]  lu_req_wa;
  logic        lu_req_ready;
  logic        lu_resp_valid;
  logic [4:0]  lu_resp_wa;
  logic [31:0] lu_resp_wd;
  logic        lu_resp_ready;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic [31:0] pending;
  logic        err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [4:0]  wa;
    logic [31:0] wd;
  } exp_wr_t;

  exp_wr_t sb[$];

  typedef struct {
    logic [4:0] ra1;
    logic [4:0] ra2;
    logic       we;
    logic [4:0] wa;
    logic       exp_stall;
  } hz_vec_t;

  hz_vec_t vecs [7];

  regfile_wb_sched #(
    .MAX_PENDING (4),
    .FIFO_DEPTH  (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pipe_we       (pipe_we),
    .pipe_wa       (pipe_wa),
    .pipe_wd       (pipe_wd),
    .id_ra1        (id_ra1),
    .id_ra2        (id_ra2),
    .id_we         (id_we),
    .id_wa         (id_wa),
    .id_stall      (id_stall),
    .lu_req_valid  (lu_req_valid),
    .lu_req_wa     (lu_req_wa),
    .lu_req_ready  (lu_req_ready),
    .lu_resp_valid (lu_resp_valid),
    .lu_resp_wa    (lu_resp_wa),
    .lu_resp_wd    (lu_resp_wd),
    .lu_resp_ready (lu_resp_ready),
    .rf_we         (rf_we),
    .rf_wa         (rf_wa),
    .rf_wd         (rf_wd),
    .pending       (pending),
    .err           (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [4:0] wa, input logic [31:0] wd);
    sb.push_back('{wa: wa, wd: wd});
  endtask

  task automatic idle_inputs();
    pipe_we       = 1'b0;
    pipe_wa       = '0;
    pipe_wd       = '0;
    id_ra1        = '0;
    id_ra2        = '0;
    id_we         = 1'b0;
    id_wa         = '0;
    lu_req_valid  = 1'b0;
    lu_req_wa     = '0;
    lu_resp_valid = 1'b0;
    lu_resp_wa    = '0;
    lu_resp_wd    = '0;
  endtask

  // Every long-latency write reaching the register file must match the oldest expected one.
  always @(negedge clk) begin : sb_monitor
    exp_wr_t e;
    if (!reset && rf_we && !(pipe_we && pipe_wa != 5'd0)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got write r%0d = 0x%08h, expected none", rf_wa, rf_wd);
      end else begin
        e = sb.pop_front();
        check("sb_wa", 32'(rf_wa), 32'(e.wa));
        check("sb_wd", rf_wd, e.wd);
      end
    end
  end

  initial begin
    vecs[0] = '{ra1: 5'd5, ra2: 5'd0, we: 1'b0, wa: 5'd0, exp_stall: 1'b1};
    vecs[1] = '{ra1: 5'd0, ra2: 5'd5, we: 1'b0, wa: 5'd0, exp_stall: 1'b1};
    vecs[2] = '{ra1: 5'd0, ra2: 5'd0, we: 1'b1, wa: 5'd5, exp_stall: 1'b1};
    vecs[3] = '{ra1: 5'd0, ra2: 5'd0, we: 1'b0, wa: 5'd5, exp_stall: 1'b0};
    vecs[4] = '{ra1: 5'd0, ra2: 5'd0, we: 1'b1, wa: 5'd0, exp_stall: 1'b0};
    vecs[5] = '{ra1: 5'd6, ra2: 5'd4, we: 1'b1, wa: 5'd6, exp_stall: 1'b0};
    vecs[6] = '{ra1: 5'd5, ra2: 5'd5, we: 1'b1, wa: 5'd5, exp_stall: 1'b1};

    idle_inputs();
    reset = 1'b1;
    #2;
    check("rst_pending", pending, 32'h0);
    check("rst_rf_we", 32'(rf_we), 32'h0);
    check("rst_id_stall", 32'(id_stall), 32'h0);
    check("rst_req_ready", 32'(lu_req_ready), 32'h1);
    check("rst_resp_ready", 32'(lu_resp_ready), 32'h1);
    check("rst_err", 32'(err), 32'h0);
    step();
    reset = 1'b0;

    // Issue r5, then hazard table against pending = {r5}.
    lu_req_valid = 1'b1;
    lu_req_wa    = 5'd5;
    #1 check("issue5_ready", 32'(lu_req_ready), 32'h1);
    step();
    lu_req_valid = 1'b0;
    check("issue5_pending", pending, 32'h0000_0020);
    for (int i = 0; i < 7; i++) begin
      id_ra1 = vecs[i].ra1;
      id_ra2 = vecs[i].ra2;
      id_we  = vecs[i].we;
      id_wa  = vecs[i].wa;
      #1 check($sformatf("hazard_vec%0d", i), 32'(id_stall), 32'(vecs[i].exp_stall));
    end
    id_ra2 = '0;
    id_we  = 1'b0;
    id_wa  = '0;
    id_ra1 = 5'd5;
    lu_req_valid = 1'b1;
    lu_req_wa    = 5'd5;
    #1 check("reissue5_ready", 32'(lu_req_ready), 32'h0);
    lu_req_valid = 1'b0;

    // Response r5; drained while WB writes r0, which must not hold the FIFO.
    lu_resp_valid = 1'b1;
    lu_resp_wa    = 5'd5;
    lu_resp_wd    = 32'hDEAD_BEEF;
    expect_wr(5'd5, 32'hDEAD_BEEF);
    step();
    lu_resp_valid = 1'b0;
    pipe_we = 1'b1;
    pipe_wa = 5'd0;
    pipe_wd = 32'h0000_FFFF;
    #1;
    check("resp5_rf_we", 32'(rf_we), 32'h1);
    check("resp5_rf_wa", 32'(rf_wa), 32'd5);
    check("resp5_rf_wd", rf_wd, 32'hDEAD_BEEF);
    check("resp5_still_stall", 32'(id_stall), 32'h1);
    step();
    pipe_we = 1'b0;
    check("resp5_pending_clr", pending, 32'h0);
    check("resp5_stall_drop", 32'(id_stall), 32'h0);
    id_ra1 = '0;

    // Pipeline holds the port for three cycles while r7 and r8 return.
    lu_req_valid = 1'b1;
    lu_req_wa    = 5'd7;
    step();
    lu_req_wa    = 5'd8;
    step();
    lu_req_valid = 1'b0;
    pipe_we = 1'b1;
    pipe_wa = 5'd3;
    pipe_wd = 32'h3333_3333;
    lu_resp_valid = 1'b1;
    lu_resp_wa    = 5'd7;
    lu_resp_wd    = 32'h7777_0007;
    expect_wr(5'd7, 32'h7777_0007);
    #1;
    check("pipe_c1_rf_wa", 32'(rf_wa), 32'd3);
    check("pipe_c1_rf_wd", rf_wd, 32'h3333_3333);
    check("pipe_c1_resp_ready", 32'(lu_resp_ready), 32'h1);
    step();
    lu_resp_wa = 5'd8;
    lu_resp_wd = 32'h8888_0008;
    expect_wr(5'd8, 32'h8888_0008);
    #1;
    check("pipe_c2_rf_wa", 32'(rf_wa), 32'd3);
    check("pipe_c2_resp_ready", 32'(lu_resp_ready), 32'h1);
    step();
    lu_resp_valid = 1'b0;
    #1;
    check("pipe_c3_rf_wa", 32'(rf_wa), 32'd3);
    check("fifo_full_resp_ready", 32'(lu_resp_ready), 32'h0);
    check("fifo_full_err", 32'(err), 32'h0);
    step();
    pipe_we = 1'b0;
    #1 check("drain_r7", 32'(rf_wa), 32'd7);
    step();
    check("drain_r8", 32'(rf_wa), 32'd8);
    check("drain_pending_r8", pending, 32'h0000_0100);
    step();
    check("drain_pending_clr", pending, 32'h0);
    check("drain_idle_rf_we", 32'(rf_we), 32'h0);

    // Fill the outstanding budget, then free one slot.
    lu_req_valid = 1'b1;
    for (int r = 1; r <= 4; r++) begin
      lu_req_wa = 5'(r);
      #1 check($sformatf("fill_ready_r%0d", r), 32'(lu_req_ready), 32'h1);
      step();
    end
    lu_req_wa = 5'd10;
    #1 check("fill_ready_5th", 32'(lu_req_ready), 32'h0);
    lu_req_valid  = 1'b0;
    lu_resp_valid = 1'b1;
    lu_resp_wa    = 5'd1;
    lu_resp_wd    = 32'h1111_0001;
    expect_wr(5'd1, 32'h1111_0001);
    step();
    lu_resp_valid = 1'b0;
    #1 check("fill_pop_cycle_ready", 32'(lu_req_ready), 32'h0);
    step();
    check("fill_reenabled", 32'(lu_req_ready), 32'h1);
    for (int r = 2; r <= 4; r++) begin
      lu_resp_valid = 1'b1;
      lu_resp_wa    = 5'(r);
      lu_resp_wd    = 32'h1111_0000 | 32'(r);
      expect_wr(5'(r), 32'h1111_0000 | 32'(r));
      #1 check($sformatf("fill_resp_ready_r%0d", r), 32'(lu_resp_ready), 32'h1);
      step();
    end
    lu_resp_valid = 1'b0;
    step();
    step();
    check("fill_pending_clr", pending, 32'h0);
    check("fill_err", 32'(err), 32'h0);

    // Issue to r0: counted but never pending, and its result is silent.
    lu_req_valid = 1'b1;
    lu_req_wa    = 5'd0;
    #1 check("r0_issue_ready", 32'(lu_req_ready), 32'h1);
    step();
    lu_req_valid = 1'b0;
    check("r0_pending", pending, 32'h0);
    lu_resp_valid = 1'b1;
    lu_resp_wa    = 5'd0;
    lu_resp_wd    = 32'h5555_5555;
    step();
    lu_resp_valid = 1'b0;
    #1 check("r0_rf_we", 32'(rf_we), 32'h0);
    step();
    check("r0_err", 32'(err), 32'h0);
    lu_req_valid = 1'b1;
    for (int r = 11; r <= 14; r++) begin
      lu_req_wa = 5'(r);
      #1 check($sformatf("r0_count_ready_r%0d", r), 32'(lu_req_ready), 32'h1);
      step();
    end
    lu_req_wa = 5'd15;
    #1 check("r0_count_full", 32'(lu_req_ready), 32'h0);
    lu_req_valid = 1'b0;

    // Unsolicited r9 sets err; reset with the FIFO full clears everything at once.
    pipe_we = 1'b1;
    pipe_wa = 5'd3;
    pipe_wd = 32'h3333_0003;
    lu_resp_valid = 1'b1;
    lu_resp_wa    = 5'd9;
    lu_resp_wd    = 32'h9999_0009;
    expect_wr(5'd9, 32'h9999_0009);
    step();
    check("unsol_err", 32'(err), 32'h1);
    lu_resp_wa = 5'd11;
    lu_resp_wd = 32'hBBBB_000B;
    expect_wr(5'd11, 32'hBBBB_000B);
    step();
    lu_resp_valid = 1'b0;
    check("unsol_err_sticky", 32'(err), 32'h1);
    check("unsol_fifo_full", 32'(lu_resp_ready), 32'h0);
    reset   = 1'b1;
    pipe_we = 1'b0;
    #1;
    check("midrst_err", 32'(err), 32'h0);
    check("midrst_pending", pending, 32'h0);
    check("midrst_resp_ready", 32'(lu_resp_ready), 32'h1);
    check("midrst_rf_we", 32'(rf_we), 32'h0);
    check("midrst_req_ready", 32'(lu_req_ready), 32'h1);
    sb.delete();
    step();
    reset = 1'b0;

    // A stale result arriving after reset is a protocol error.
    lu_resp_valid = 1'b1;
    lu_resp_wa    = 5'd12;
    lu_resp_wd    = 32'hCCCC_000C;
    expect_wr(5'd12, 32'hCCCC_000C);
    step();
    lu_resp_valid = 1'b0;
    check("stale_err", 32'(err), 32'h1);
    step();
    step();
    check("stale_pending", pending, 32'h0);
    check("sb_drained", 32'(sb.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_sched.md
Name: regfile_wb_sched

Overview:
- Write-back scheduler and scoreboard in front of the 31x32 register file (r0 hardwired zero, single write port, combinational reads with no write-through).
- Shares the one write port between the in-order pipeline WB stage and a long-latency unit (mult/div/uncached load) that returns results out of band.
- Tracks destinations still pending from the long-latency unit and raises a decode stall for RAW/WAW hazards against them.

Parameters:
- MAX_PENDING, 4, max outstanding long-latency ops (1..8).
- FIFO_DEPTH, 2, result buffer entries (power of two, >=2).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- pipe_we  in  1  WB stage write enable
- pipe_wa  in  5  WB destination
- pipe_wd  in  32  WB data
- id_ra1, id_ra2  in  5 each  decode source registers
- id_we  in  1  decode instruction writes a register
- id_wa  in  5  decode destination
- id_stall  out  1  hazard against a pending register
- lu_req_valid  in  1  long-latency issue
- lu_req_wa  in  5  its destination
- lu_req_ready  out  1  issue accepted
- lu_resp_valid  in  1  result valid
- lu_resp_wa  in  5  result destination
- lu_resp_wd  in  32  result data
- lu_resp_ready  out  1  result accepted
- rf_we  out  1  register file write enable
- rf_wa  out  5  register file write address
- rf_wd  out  32  register file write data
- pending  out  32  scoreboard, bit 0 always 0
- err  out  1  sticky protocol error

Behaviour:
- Reset (async, active-high): pending=0, outstanding count=0, FIFO empty, err=0. Outputs rf_we=0, id_stall=0, lu_req_ready=1, lu_resp_ready=1.
- Issue handshake:
  - lu_req_ready = (count < MAX_PENDING) && !(lu_req_wa!=0 && pending[lu_req_wa]).
  - On valid&&ready: count+1; if wa!=0, set pending[wa] at clock edge.
- Response handshake:
  - lu_resp_ready = FIFO not full.
  - On valid&&ready: push {wa,wd} into the FIFO.
  - If wa!=0 and pending[wa]==0 and no queued entry holds wa: set err (sticky until reset); entry is still pushed.
- Write-port arbitration (combinational, same cycle):
  - If pipe_we && pipe_wa!=0: rf_we=1, rf_wa=pipe_wa, rf_wd=pipe_wd. FIFO holds.
  - Else if FIFO non-empty: pop the head. rf_we=(head.wa!=0), rf_wa=head.wa, rf_wd=head.wd.
  - Pipeline always wins and is never back-pressured.
  - pipe_we with pipe_wa=0 counts as idle for arbitration.
- Pop at edge: count-1; clear pending[head.wa].
  - The clear takes effect the cycle after the register file write. Readers see the new value exactly when the stall drops.
- Hazard: id_stall = pending[id_ra1] | pending[id_ra2] | (id_we & pending[id_wa]). Index 0 is never pending. Purely combinational from registered state.
- Simultaneous events:
  - Issue sets reg A while a pop clears reg B: both apply.
  - Set and clear of the same register in one cycle is impossible, because ready is low while it is pending.
  - Push and pop in the same cycle with the FIFO full: not accepted, since ready reflects registered fullness.
  - Issue and pop in the same cycle: count unchanged.
- Latency:
  - Response to register file write is 1 cycle minimum (registered FIFO, no bypass). Longer while the pipeline writes.
  - pending clears 1 cycle after the write.
- Count width is clog2(MAX_PENDING+1). Underflow (pop with count 0) sets err and count saturates at 0.
- Reset mid-operation: all state discarded immediately. In-flight long-latency results arriving after reset are flagged as err.

Decomposition:
- Shared package gains:
  - creg_addr_t (5-bit)
  - wb_entry_t struct {creg_addr_t wa; word_t wd;}
  - NUM_CREGS=32
- word_t comes from the existing common header.
- Sub-module: wb_fifo, a synchronous FIFO of wb_entry_t with FIFO_DEPTH parameter and full/empty/push/pop.
- Scoreboard, counter and arbiter live in the top module.

Test Plan:
- Reset, then issue wa=5 -> pending[5]=1 next cycle. id_ra1=5 gives id_stall=1. A second issue with wa=5 sees lu_req_ready=0.
- Response wa=5, wd=0xDEADBEEF with pipe_we=0 -> rf_we=1, rf_wa=5, rf_wd=0xDEADBEEF one cycle later. pending[5]=0 the following cycle; id_stall drops.
- Pipeline writes r3 for 3 consecutive cycles while responses for r7 and r8 arrive:
  - rf_wa=3 each of those cycles.
  - FIFO fills and lu_resp_ready=0.
  - r7 then r8 are written on the next two idle cycles, in order.
- Issue 4 ops (regs 1..4) -> lu_req_ready=0 on the 5th. Draining one response re-enables ready the next cycle.
- Issue with wa=0 -> no pending bit set, count=1. Its response produces rf_we=0, count returns to 0, err stays 0.
- Response wa=9 with nothing pending -> err=1 and stays 1. Assert reset mid-FIFO -> err=0, FIFO empty, pending=0 immediately.
